rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Parametrised RC4 keystream-generation and decryption core: the successor to the fixed 32-byte decrypt FSM. It runs the PRGA over an already-shuffled S RAM and XORs the keystream with the encrypted-message RAM (E) into the decrypted RAM (D). New in this block:
- runtime message length;
- configurable RAM read latency;
- optional plaintext-validity check that aborts early and reports pass/fail to the key-search controller.

It sits between the key-schedule shuffle block and the key-search controller, and shares the S/E/D RAMs through the existing request/grant arbiters.

## Interface
- DATA_W, 8: S/E/D data width; must equal S_ADDR_W.
- S_ADDR_W, 8: S RAM address width.
- MSG_ADDR_W, 5: E/D address width; maximum message length is 2**MSG_ADDR_W.
- RD_LAT, 2: RAM read latency in cycles (≥1).
- CHAR_LO / CHAR_HI / CHAR_SP, 8'h61 / 8'h7A / 8'h20: valid plaintext set.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- start  in  1  level request to run.
- msg_len  in  MSG_ADDR_W+1  byte count; latched on IDLE→REQ.
- check_en  in  1  enable validity check; latched on IDLE→REQ.
- finish  out  1  high while in DONE.
- pass / fail  out  1  result; valid while finish is high.
- s_req, e_req, d_req  out  1  RAM access requests.
- s_gnt, e_gnt, d_gnt  in  1  grants.
- s_addr  out  S_ADDR_W.
- s_wdata  out  DATA_W.
- s_wren  out  1.
- s_q  in  DATA_W.
- e_addr  out  MSG_ADDR_W.
- e_q  in  DATA_W.
- d_addr  out  MSG_ADDR_W.
- d_wdata  out  DATA_W.
- d_wren  out  1.

## Operation
**Reset.** Async reset forces state to IDLE. All outputs go to 0, including addresses and data. The registers i, j, k, si, sj, f and the latched msg_len/check_en all clear.

**States:** IDLE, REQ, INIT, RD_I, CALC_J, RD_J, WR_I, WR_J, RD_F, WR_D, NEXT, DONE.

**Transitions:**
- IDLE → REQ when start is high. If msg_len == 0, go IDLE → DONE directly with pass=1 and no RAM activity.
- REQ: assert all three requests. Stay until s_gnt, e_gnt and d_gnt are all high in the same cycle, then go to INIT. Requests stay high through WR_D. Grants are sampled only in REQ; the arbiter holds a grant until its request drops.
- INIT: i=1, j=0, k=0.
- RD_I: s_addr=i for RD_LAT cycles; capture si=s_q in the last cycle.
- CALC_J: j = j + si (mod 2**S_ADDR_W).
- RD_J: s_addr=j for RD_LAT cycles; capture sj.
- WR_I: write s[i]=sj.
- WR_J: write s[j]=si. When i==j, both writes carry the same value; no special case.
- RD_F: s_addr = si + sj (mod 2**S_ADDR_W) and e_addr=k for RD_LAT cycles; capture f=s_q.
- WR_D: d_addr=k, d_wdata = f ^ e_q, d_wren=1.
  - If check_en is set and the byte is not in [CHAR_LO..CHAR_HI] ∪ {CHAR_SP}: set fail=1 and go to DONE. The invalid byte is still written.
  - Else if k == msg_len−1: set pass=1 and go to DONE.
  - Else go to NEXT.
- NEXT: i++ (wraps mod 2**S_ADDR_W), k++, then go to RD_I.
- DONE: requests low, finish=1. Stay while start is high; go to IDLE the cycle after start falls. pass/fail clear on leaving DONE.

**Other rules:**
- start falling mid-operation is ignored.
- rst_n asserted mid-operation aborts immediately. Partially written S/D contents are not restored.
- s_wren is high only in WR_I and WR_J.
- e_addr holds k throughout; d_addr holds k.

## Timing
- Per-byte cost: 3·RD_LAT+4 cycles (RD_I through WR_D), plus 1 cycle of NEXT between bytes.
- Take the REQ cycle in which all grants are high as cycle 0. finish first rises in cycle N·(3·RD_LAT+5)+1, where N = msg_len, for a run with no abort.
- finish, pass and fail are registered (state-decoded); none is combinational from inputs.
- d_wren is a single-cycle pulse per byte.

## Structure
- Package rc4_pkg holds:
  - the state enum `rc4_prga_state_t`;
  - default CHAR_LO/CHAR_HI/CHAR_SP constants, shared with the key-search controller.
- Sub-module rc4_char_valid: combinational byte-in-set check, parametrised on DATA_W and the char constants, reused by the controller.
- The read-latency wait is a local counter of width $clog2(RD_LAT+1), reloaded on entry to each RD_* state.

## Test plan
1. **Identity S, no check.** s[x]=x, E=0, msg_len=4, check_en=0, RD_LAT=2 → D = 02,05,07,0D. pass=1, fail=0; finish rises in cycle 45.
2. **Abort in check mode.** Same S, E[0]=63, E[1]=00, check_en=1 → d[0]=61, d[1]=05 written. fail=1, pass=0; d[2] is never written; exactly 2 d_wren pulses.
3. **Grant stall.** s_gnt held low 10 cycles with e_gnt=d_gnt=1 → FSM stays in REQ with s_wren=d_wren=0. The run then completes as in test 1, shifted 10 cycles.
4. **Reset mid-run.** rst_n pulsed low during byte 2 → all outputs 0 immediately, state IDLE. Reload S, restart → D matches test 1.
5. **Long run with wrap.** MSG_ADDR_W=9, msg_len=300 → i wraps 255→0 at byte 255. D matches the software RC4 model; msg_len=0 gives finish with pass=1 and no requests.
6. **Handshake hold and release.** start held 5 cycles after finish → DONE held, pass stable. start falls → IDLE next cycle with pass/fail=0. start reasserted → new run.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt datapath and the key-search controller.
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ,
      ST_INIT,
      ST_RD_I,
      ST_CALC_J,
      ST_RD_J,
      ST_WR_I,
      ST_WR_J,
      ST_RD_F,
      ST_WR_D,
      ST_NEXT,
      ST_DONE
   } rc4_prga_state_t;

   // Valid plaintext: lowercase letters plus space.
   localparam logic [7:0] CHAR_LO_DEF = 8'h61;
   localparam logic [7:0] CHAR_HI_DEF = 8'h7A;
   localparam logic [7:0] CHAR_SP_DEF = 8'h20;

endpackage

// File: rtl/rc4_char_valid.sv
// Combinational plaintext-byte membership test: [CHAR_LO..CHAR_HI] or CHAR_SP.
module rc4_char_valid
   import rc4_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] CHAR_LO = DATA_W'(CHAR_LO_DEF),
   parameter logic [DATA_W-1:0] CHAR_HI = DATA_W'(CHAR_HI_DEF),
   parameter logic [DATA_W-1:0] CHAR_SP = DATA_W'(CHAR_SP_DEF)
) (
   input  logic [DATA_W-1:0] char_in,
   output logic              valid
);

   assign valid = ((char_in >= CHAR_LO) && (char_in <= CHAR_HI)) || (char_in == CHAR_SP);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over a pre-shuffled S RAM, XORed with E into D.
// Runtime message length, configurable RAM read latency, optional early-abort
// plaintext check reporting pass/fail.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; latches msg_len / check_en
// REQ    | requesting S/E/D RAMs, waiting for all three grants
// INIT   | i=1, j=0, k=0
// RD_I   | reading s[i] for RD_LAT cycles -> si
// CALC_J | j += si
// RD_J   | reading s[j] for RD_LAT cycles -> sj
// WR_I   | s[i] = sj
// WR_J   | s[j] = si
// RD_F   | reading s[si+sj] -> f and e[k] for RD_LAT cycles
// WR_D   | d[k] = f ^ e[k]; check byte / detect last byte
// NEXT   | i++, k++
// DONE   | finish high, result valid; held while start is high
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                S_ADDR_W   = 8,
   parameter int                MSG_ADDR_W = 5,
   parameter int                RD_LAT     = 2,
   parameter logic [DATA_W-1:0] CHAR_LO    = DATA_W'(CHAR_LO_DEF),
   parameter logic [DATA_W-1:0] CHAR_HI    = DATA_W'(CHAR_HI_DEF),
   parameter logic [DATA_W-1:0] CHAR_SP    = DATA_W'(CHAR_SP_DEF)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [MSG_ADDR_W:0]   msg_len,
   input  logic                  check_en,
   output logic                  finish,
   output logic                  pass,
   output logic                  fail,
   output logic                  s_req,
   output logic                  e_req,
   output logic                  d_req,
   input  logic                  s_gnt,
   input  logic                  e_gnt,
   input  logic                  d_gnt,
   output logic [S_ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   output logic                  s_wren,
   input  logic [DATA_W-1:0]     s_q,
   output logic [MSG_ADDR_W-1:0] e_addr,
   input  logic [DATA_W-1:0]     e_q,
   output logic [MSG_ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0]     d_wdata,
   output logic                  d_wren
);

   localparam int                LAT_W    = $clog2(RD_LAT + 1);
   localparam int                LEN_W    = MSG_ADDR_W + 1;
   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT - 1);

   rc4_prga_state_t       state, state_nxt;
   logic [S_ADDR_W-1:0]   i, j, f_addr;
   logic [MSG_ADDR_W-1:0] k;
   logic [DATA_W-1:0]     si, sj, f, e_byte, d_byte;
   logic [LEN_W-1:0]      len_q;
   logic                  chk_q, pass_q, fail_q;
   logic [LAT_W-1:0]      lat_cnt;
   logic                  lat_done, byte_ok, last_byte, active;

   assign lat_done  = (lat_cnt == '0);
   assign f_addr    = si + sj;
   assign d_byte    = f ^ e_byte;
   assign last_byte = ({1'b0, k} == (len_q - LEN_W'(1)));
   assign active    = (state != ST_IDLE) && (state != ST_DONE);

   rc4_char_valid #(
      .DATA_W  (DATA_W),
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI),
      .CHAR_SP (CHAR_SP)
   ) u_char_valid (
      .char_in (d_byte),
      .valid   (byte_ok)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = (msg_len == '0) ? ST_DONE : ST_REQ;
         ST_REQ:    if (s_gnt && e_gnt && d_gnt) state_nxt = ST_INIT;
         ST_INIT:   state_nxt = ST_RD_I;
         ST_RD_I:   if (lat_done) state_nxt = ST_CALC_J;
         ST_CALC_J: state_nxt = ST_RD_J;
         ST_RD_J:   if (lat_done) state_nxt = ST_WR_I;
         ST_WR_I:   state_nxt = ST_WR_J;
         ST_WR_J:   state_nxt = ST_RD_F;
         ST_RD_F:   if (lat_done) state_nxt = ST_WR_D;
         ST_WR_D:   state_nxt = ((chk_q && !byte_ok) || last_byte) ? ST_DONE : ST_NEXT;
         ST_NEXT:   state_nxt = ST_RD_I;
         ST_DONE:   if (!start) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // S RAM port decode; only the two swap states write.
   always_comb begin
      s_addr  = '0;
      s_wdata = '0;
      s_wren  = 1'b0;
      case (state)
         ST_RD_I: s_addr = i;
         ST_RD_J: s_addr = j;
         ST_WR_I: begin
            s_addr  = i;
            s_wdata = sj;
            s_wren  = 1'b1;
         end
         ST_WR_J: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
         end
         ST_RD_F: s_addr = f_addr;
         default: ;
      endcase
   end

   assign s_req   = active;
   assign e_req   = active;
   assign d_req   = active;
   assign e_addr  = k;
   assign d_addr  = k;
   assign d_wren  = (state == ST_WR_D);
   assign d_wdata = (state == ST_WR_D) ? d_byte : '0;
   assign finish  = (state == ST_DONE);
   assign pass    = pass_q;
   assign fail    = fail_q;

   // Datapath: indices, captured RAM data, latency down-counter and result flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i       <= '0;
         j       <= '0;
         k       <= '0;
         si      <= '0;
         sj      <= '0;
         f       <= '0;
         e_byte  <= '0;
         len_q   <= '0;
         chk_q   <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         lat_cnt <= '0;
      end else begin
         // Every RD_* state is entered from a different state, so a state
         // change is exactly where the wait must restart.
         if (state_nxt != state)  lat_cnt <= LAT_LOAD;
         else if (!lat_done)      lat_cnt <= lat_cnt - LAT_W'(1);

         case (state)
            ST_IDLE: if (start) begin
               len_q <= msg_len;
               chk_q <= check_en;
               if (msg_len == '0) pass_q <= 1'b1;
            end
            ST_INIT: begin
               i <= S_ADDR_W'(1);
               j <= '0;
               k <= '0;
            end
            ST_RD_I:   if (lat_done) si <= s_q;
            ST_CALC_J: j <= j + si;
            ST_RD_J:   if (lat_done) sj <= s_q;
            ST_RD_F: if (lat_done) begin
               f      <= s_q;
               e_byte <= e_q;
            end
            ST_WR_D: begin
               if (chk_q && !byte_ok) fail_q <= 1'b1;
               else if (last_byte)    pass_q <= 1'b1;
            end
            ST_NEXT: begin
               i <= i + S_ADDR_W'(1);
               k <= k + MSG_ADDR_W'(1);
            end
            ST_DONE: if (!start) begin
               pass_q <= 1'b0;
               fail_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt with a software RC4 reference model.
module tb_rc4_prga_decrypt;

   localparam int MAW = 9;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           start = 1'b0;
   logic [MAW:0]   msg_len = '0;
   logic           check_en = 1'b0;
   logic           finish, pass, fail;
   logic           s_req, e_req, d_req;
   logic           s_gnt = 1'b1, e_gnt = 1'b1, d_gnt = 1'b1;
   logic [7:0]     s_addr, s_wdata, s_q, e_q, d_wdata;
   logic           s_wren, d_wren;
   logic [MAW-1:0] e_addr, d_addr;

   rc4_prga_decrypt #(
      .DATA_W(8), .S_ADDR_W(8), .MSG_ADDR_W(MAW), .RD_LAT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len), .check_en(check_en),
      .finish(finish), .pass(pass), .fail(fail),
      .s_req(s_req), .e_req(e_req), .d_req(d_req),
      .s_gnt(s_gnt), .e_gnt(e_gnt), .d_gnt(d_gnt),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
      .e_addr(e_addr), .e_q(e_q),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM models with one cycle of registered read (RD_LAT = 2).
   logic [7:0] s_init [256];
   logic [7:0] e_init [512];
   logic [7:0] s_mem  [256];
   logic [7:0] e_mem  [512];
   logic [7:0] d_mem  [512];
   bit         d_valid[512];
   bit         ld_go = 1'b0;
   int         d_wr_cnt = 0;

   always @(posedge clk) begin
      if (ld_go) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
         for (int x = 0; x < 512; x++) begin
            e_mem[x]   <= e_init[x];
            d_valid[x] <= 1'b0;
         end
      end else begin
         if (s_wren) s_mem[s_addr] <= s_wdata;
         if (d_wren) begin
            d_mem[d_addr]   <= d_wdata;
            d_valid[d_addr] <= 1'b1;
            d_wr_cnt        <= d_wr_cnt + 1;
         end
      end
      s_q <= s_mem[s_addr];
      e_q <= e_mem[e_addr];
   end

   int         vec = 0;
   int         errs = 0;
   int         t0 = 0;
   bit         req_seen = 1'b0;
   bit         seen_req = 1'b0;
   bit         prev_dw = 1'b0;
   int         exp_n = 0;
   logic [7:0] exp_d [512];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit is_text(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
   endfunction

   // Reference RC4 PRGA + decrypt; stops after the first invalid byte in check mode.
   task automatic model(input int len, input bit chk_on, output int m, output bit p, output bit f);
      logic [7:0] s[256];
      logic [7:0] t, b;
      int ii, jj;
      ii = 0; jj = 0; m = 0; p = (len == 0); f = 1'b0;
      for (int x = 0; x < 256; x++) s[x] = s_init[x];
      for (int kk = 0; kk < len; kk++) begin
         ii = (ii + 1) % 256;
         jj = (jj + int'(s[ii])) % 256;
         t = s[ii]; s[ii] = s[jj]; s[jj] = t;
         b = s[(int'(s[ii]) + int'(s[jj])) % 256] ^ e_init[kk];
         exp_d[kk] = b;
         m = kk + 1;
         if (chk_on && !is_text(b)) begin
            f = 1'b1;
            break;
         end
         if (kk == len - 1) p = 1'b1;
      end
   endtask

   // One sample point per cycle, away from the active edge; checks every D write.
   task automatic tick();
      @(negedge clk);
      if (s_req && s_gnt && e_gnt && d_gnt && !req_seen) begin
         t0 = cyc;
         req_seen = 1'b1;
      end
      if (!s_req) req_seen = 1'b0;
      if (s_req)  seen_req = 1'b1;
      if (d_wren) begin
         chk("d_wdata", 32'(d_wdata), 32'(exp_d[d_addr]));
         chk("d_addr_in_range", 32'(int'(d_addr) < exp_n), 32'd1);
         chk("e_addr_eq_d_addr", 32'(e_addr), 32'(d_addr));
         chk("d_wren_pulse", 32'(prev_dw), 32'd0);
      end
      prev_dw = d_wren;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, 32'({s_req, e_req, d_req, s_wren, d_wren, finish, pass, fail}), 32'd0);
      chk({nm, "_s"},   32'({s_addr, s_wdata}), 32'd0);
      chk({nm, "_ed"},  32'({e_addr, d_addr, d_wdata}), 32'd0);
   endtask

   task automatic set_s(input int mul, input int add);
      for (int x = 0; x < 256; x++) s_init[x] = 8'((x * mul + add) % 256);
   endtask

   // Builds E so that the first four decrypted bytes equal pt (MSB byte first).
   task automatic set_pt(input logic [31:0] pt);
      int m; bit p, f;
      logic [7:0] pb;
      for (int x = 0; x < 4; x++) e_init[x] = 8'h00;
      model(4, 1'b0, m, p, f);
      for (int x = 0; x < 4; x++) begin
         pb = pt[31 - 8*x -: 8];
         e_init[x] = exp_d[x] ^ pb;
      end
   endtask

   task automatic run_case(input string nm, input int len, input bit chk_on,
                           input int stall, input int hold);
      int m, c0, tf, base;
      bit ep, ef, done;
      model(len, chk_on, m, ep, ef);
      exp_n = m;
      ld_go = 1'b1;
      @(posedge clk);
      #1 ld_go = 1'b0;
      base     = d_wr_cnt;
      seen_req = 1'b0;
      msg_len  = (MAW+1)'(len);
      check_en = chk_on;
      s_gnt    = (stall == 0);
      start    = 1'b1;
      c0       = cyc;
      for (int n = 0; n <= stall; n++) begin
         tick();
         if (n > 0) chk({nm, "_stall"}, 32'({s_req, s_wren, d_wren, finish}), 32'(4'b1000));
      end
      @(posedge clk);
      #1 s_gnt = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 20000 && !done; w++) begin
         tick();
         if (finish) done = 1'b1;
      end
      tf = cyc;
      chk({nm, "_finish_seen"}, 32'(done), 32'd1);
      if (len == 0) begin
         chk({nm, "_finish_cyc"}, 32'(tf - c0), 32'd1);
         chk({nm, "_no_req"}, 32'(seen_req), 32'd0);
      end else begin
         chk({nm, "_grant_cyc"}, 32'(t0 - c0), 32'(stall + 1));
         chk({nm, "_finish_cyc"}, 32'(tf - t0), 32'(m * 11 + 1));
      end
      chk({nm, "_pass_fail"}, 32'({pass, fail}), 32'({ep, ef}));
      chk({nm, "_wr_count"}, 32'(d_wr_cnt - base), 32'(m));
      if (m < len) chk({nm, "_no_write_after_abort"}, 32'(d_valid[m]), 32'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({nm, "_hold"}, 32'({finish, pass, fail}), 32'({1'b1, ep, ef}));
      end
      start = 1'b0;
      tick();
      chk({nm, "_release"}, 32'({finish, pass, fail, s_req}), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  m, base;
      bit  ep, ef, ok;
      set_s(1, 0);
      for (int x = 0; x < 512; x++) e_init[x] = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      // Identity S, E = 0, no check.
      run_case("t1_ident", 4, 1'b0, 0, 0);
      chk("t1_model_k0", 32'(exp_d[0]), 32'h02);
      chk("t1_model_k1", 32'(exp_d[1]), 32'h05);
      chk("t1_model_k2", 32'(exp_d[2]), 32'h07);
      chk("t1_model_k3", 32'(exp_d[3]), 32'h0D);
      chk("t1_d0", 32'(d_mem[0]), 32'h02);
      chk("t1_d3", 32'(d_mem[3]), 32'h0D);

      // Check mode aborts on 0x05 after writing it.
      e_init[0] = 8'h63;
      e_init[1] = 8'h00;
      run_case("t2_abort", 4, 1'b1, 0, 0);
      chk("t2_d0", 32'(d_mem[0]), 32'h61);
      chk("t2_d1", 32'(d_mem[1]), 32'h05);
      chk("t2_d2_unwritten", 32'(d_valid[2]), 32'd0);
      e_init[0] = 8'h00;

      // S grant withheld for 10 REQ cycles.
      run_case("t3_stall", 4, 1'b0, 10, 0);
      chk("t3_d3", 32'(d_mem[3]), 32'h0D);

      // Reset asserted during byte 2.
      model(4, 1'b0, m, ep, ef);
      exp_n = m;
      ld_go = 1'b1;
      @(posedge clk);
      #1 ld_go = 1'b0;
      base = d_wr_cnt;
      msg_len = 10'd4;
      check_en = 1'b0;
      start = 1'b1;
      ok = 1'b0;
      for (int w = 0; w < 300 && !ok; w++) begin
         tick();
         if (d_wr_cnt - base >= 2) ok = 1'b1;
      end
      chk("t4_reach_byte2", 32'(ok), 32'd1);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      start = 1'b0;
      #1 chk_zero("t4_rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t4_wr_count", 32'(d_wr_cnt - base), 32'd2);
      chk("t4_d2_unwritten", 32'(d_valid[2]), 32'd0);
      chk("t4_idle_no_req", 32'({s_req, finish}), 32'd0);
      run_case("t4_rerun", 4, 1'b0, 0, 0);
      chk("t4_d0", 32'(d_mem[0]), 32'h02);
      chk("t4_d2", 32'(d_mem[2]), 32'h07);

      // Plaintext set boundaries in check mode.
      set_pt({8'h61, 8'h7a, 8'h20, 8'h6d});
      run_case("txt_valid", 4, 1'b1, 0, 0);
      chk("txt_valid_d1", 32'(d_mem[1]), 32'h7a);
      set_pt({8'h61, 8'h20, 8'h7a, 8'h60});
      run_case("txt_below_lo", 4, 1'b1, 0, 0);
      chk("txt_below_lo_d3", 32'(d_mem[3]), 32'h60);
      set_pt({8'h7a, 8'h7b, 8'h61, 8'h61});
      run_case("txt_above_hi", 4, 1'b1, 0, 0);

      // Long run wrapping i, then hold DONE for 5 cycles.
      set_s(7, 3);
      for (int x = 0; x < 512; x++) e_init[x] = 8'((x * 13) % 256);
      run_case("t5_long", 300, 1'b0, 0, 5);
      run_case("t5_zero", 0, 1'b0, 0, 2);

      // Restart after release.
      set_s(1, 0);
      for (int x = 0; x < 512; x++) e_init[x] = 8'h00;
      run_case("t6_restart", 4, 1'b0, 0, 0);
      chk("t6_d1", 32'(d_mem[1]), 32'h05);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
